// File: rtl/trace_pkt_serializer.sv
// Trace packet serializer: splits up-to-3-wide retirement packets into FIFO records.
// Optional TRACE_SER_TIMESTAMP_EN adds a free-running cycle stamp per record (rec_ts).
package trace_pkt_serializer_pkg;
  typedef struct packed {
    logic [2:0]  valid;
    logic [95:0] insn;
    logic [95:0] address;
    logic [2:0]  exception;
    logic [2:0]  interrupt;
    logic [4:0]  ecause;
    logic [31:0] tval;
  } trace_pkt_t;
endpackage

module trace_pkt_serializer
  import trace_pkt_serializer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trace_en,
  input  logic        flush,
  input  trace_pkt_t  trace_pkt,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [1:0]  rec_slot,
  output logic [31:0] rec_insn,
  output logic [31:0] rec_addr,
  output logic        rec_exc,
  output logic        rec_intr,
  output logic [4:0]  rec_ecause,
  output logic [31:0] rec_tval,
  output logic        rec_lost,
`ifdef TRACE_SER_TIMESTAMP_EN
  output logic [31:0] rec_ts,
`endif
  output logic [15:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [1:0]  slot;
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
    logic [31:0] tval;
    logic        lost;
`ifdef TRACE_SER_TIMESTAMP_EN
    logic [31:0] ts;
`endif
  } rec_t;

  rec_t mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          lost_pend_q, lost_pend_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
`ifdef TRACE_SER_TIMESTAMP_EN
  logic [31:0]   ts_q, ts_d;
`endif

  logic [2:0]    v;
  logic [1:0]    n;
  logic [CW-1:0] free;
  logic          accept, drop, pop;
  logic [1:0]    off [3];
  rec_t          wrec [3];
  rec_t          head;

  always_comb begin
    v      = trace_pkt.valid & {3{trace_en}};
    n      = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    free   = CW'(DEPTH) - count_q;
    pop    = (count_q != '0) && rec_ready;
    accept = !flush && (n != 2'd0) && (free >= CW'(n));
    drop   = !flush && (n != 2'd0) && !accept;
    off[0] = 2'd0;
    off[1] = 2'(v[0]);
    off[2] = 2'(v[0]) + 2'(v[1]);
    for (int k = 0; k < 3; k++) begin
      wrec[k].slot = 2'(k);
      wrec[k].insn = trace_pkt.insn[32*k +: 32];
      wrec[k].addr = trace_pkt.address[32*k +: 32];
      wrec[k].exc  = trace_pkt.exception[k];
      wrec[k].intr = trace_pkt.interrupt[k];
      if (trace_pkt.exception[k] || trace_pkt.interrupt[k]) begin
        wrec[k].ecause = trace_pkt.ecause;
        wrec[k].tval   = trace_pkt.tval;
      end else begin
        wrec[k].ecause = 5'd0;
        wrec[k].tval   = 32'd0;
      end
      // only the lowest valid slot lands at offset 0
      wrec[k].lost = lost_pend_q && (off[k] == 2'd0);
`ifdef TRACE_SER_TIMESTAMP_EN
      wrec[k].ts = ts_q;
`endif
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    lost_pend_d = lost_pend_q;
    drop_cnt_d  = drop_cnt_q;
`ifdef TRACE_SER_TIMESTAMP_EN
    ts_d        = ts_q + 32'd1;
`endif
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      lost_pend_d = 1'b0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + AW'(n);
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (accept ? CW'(n) : '0) - CW'(pop);
      if (accept) lost_pend_d = 1'b0;
      else if (drop) lost_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      lost_pend_q <= 1'b0;
      drop_cnt_q  <= 16'd0;
`ifdef TRACE_SER_TIMESTAMP_EN
      ts_q        <= 32'd0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      lost_pend_q <= lost_pend_d;
      drop_cnt_q  <= drop_cnt_d;
`ifdef TRACE_SER_TIMESTAMP_EN
      ts_q        <= ts_d;
`endif
    end
  end

  // storage is intentionally not reset; outputs are masked while empty
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (accept && v[k]) mem_q[wr_ptr_q + AW'(off[k])] <= wrec[k];
    end
  end

  assign rec_valid = (count_q != '0);
  assign head      = rec_valid ? mem_q[rd_ptr_q] : '0;

  assign rec_slot   = head.slot;
  assign rec_insn   = head.insn;
  assign rec_addr   = head.addr;
  assign rec_exc    = head.exc;
  assign rec_intr   = head.intr;
  assign rec_ecause = head.ecause;
  assign rec_tval   = head.tval;
  assign rec_lost   = head.lost;
`ifdef TRACE_SER_TIMESTAMP_EN
  assign rec_ts     = head.ts;
`endif
  assign drop_cnt   = drop_cnt_q;
endmodule
